// File: rtl/gsim_pkg.sv
// Shared constants and FSM state encoding for the GSIM residual checker.
// The band coefficients are what gsim_band_mac realises as shift-add terms.
package gsim_pkg;

    localparam int C0   = 20;
    localparam int C1   = -13;
    localparam int C2   = 6;
    localparam int C3   = -1;
    localparam int FRAC = 16;

    typedef enum logic [1:0] {
        LOAD_B = 2'd0,
        RUN    = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/gsim_band_mac.sv
// Combinational 7-tap band product for one row: 20/-13/6/-1, shift-add only.
// Tap 0 is x[i-3], tap 3 the row centre x[i], tap 6 is x[i+3].
module gsim_band_mac
    import gsim_pkg::*;
#(
    parameter int XW = 32,
    parameter int RW = 40
) (
    input  logic [7*XW-1:0]    i_win,
    output logic signed [RW-1:0] o_acc
);

    logic signed [RW-1:0] w_t [7];
    logic signed [RW-1:0] w_s1;
    logic signed [RW-1:0] w_s2;
    logic signed [RW-1:0] w_s3;
    logic signed [RW-1:0] w_c;

    always_comb begin
        for (int k = 0; k < 7; k++) begin
            w_t[k] = RW'(signed'(i_win[k*XW +: XW]));
        end
    end

    // Symmetric band: pair the taps first so each coefficient is applied once.
    assign w_c  = w_t[3];
    assign w_s1 = w_t[2] + w_t[4];
    assign w_s2 = w_t[1] + w_t[5];
    assign w_s3 = w_t[0] + w_t[6];

    assign o_acc = ((w_c <<< 4) + (w_c <<< 2))
                 - ((w_s1 <<< 3) + (w_s1 <<< 2) + w_s1)
                 + ((w_s2 <<< 2) + (w_s2 <<< 1))
                 - w_s3;

endmodule

// File: rtl/gsim_residual_chk.sv
// Hardware check of a GSIM solution: captures b, streams x, emits r = M*x - b per row,
// tracks the largest |r| and flags pass against TOL at the end of each run.
module gsim_residual_chk
    import gsim_pkg::*;
#(
    parameter int            N   = 16,
    parameter int            BW  = 16,
    parameter int            XW  = 32,
    parameter int            RW  = 40,
    parameter logic [RW-1:0] TOL = 40'h00_0000_0100
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          b_valid,
    input  logic [BW-1:0] b_in,
    input  logic          x_valid,
    input  logic [XW-1:0] x_in,
    output logic          r_valid,
    output logic [5:0]    r_idx,
    output logic [RW-1:0] r_out,
    output logic          done,
    output logic          pass,
    output logic [RW-1:0] max_abs,
    output logic          proto_err,
    output state_t        dbg_state
);

    localparam int            IW   = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N-1);

    // Handshake: b_in/x_in are taken on any rising edge where their valid is high and
    // the FSM is in the state that owns that stream; otherwise the beat is dropped and
    // proto_err latches. There is no ready: the checker never back-pressures GSIM.

    state_t               r_state;
    logic [IW-1:0]        r_bcnt;
    logic [IW-1:0]        r_xcnt;
    logic [IW-1:0]        r_row;
    logic [1:0]           r_fcnt;
    logic [BW-1:0]        r_b_buf [N];
    logic [6*XW-1:0]      r_win;
    logic [RW-1:0]        r_max_run;

    logic                 w_shift;
    logic                 w_emit;
    logic [XW-1:0]        w_in;
    logic [7*XW-1:0]      w_win_next;
    logic signed [RW-1:0] w_acc;
    logic signed [RW-1:0] w_bq;
    logic signed [RW-1:0] w_r;
    logic [RW-1:0]        w_abs;
    logic [RW-1:0]        w_max_next;

    // Six stored taps plus the incoming beat form the 7-deep window, so the row
    // completed by this beat is evaluated in the same cycle and registered with it.
    assign w_shift    = ((r_state == RUN) && x_valid) || (r_state == FLUSH);
    assign w_emit     = ((r_state == RUN) && x_valid && (r_xcnt >= IW'(3))) || (r_state == FLUSH);
    assign w_in       = (r_state == RUN) ? x_in : '0;
    assign w_win_next = {w_in, r_win};

    gsim_band_mac #(
        .XW (XW),
        .RW (RW)
    ) u_mac (
        .i_win (w_win_next),
        .o_acc (w_acc)
    );

    assign w_bq       = RW'(signed'(r_b_buf[r_row])) <<< FRAC;
    assign w_r        = w_acc - w_bq;
    assign w_abs      = w_r[RW-1] ? RW'(-w_r) : RW'(w_r);
    assign w_max_next = (w_abs > r_max_run) ? w_abs : r_max_run;
    assign dbg_state  = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= LOAD_B;
            r_bcnt    <= '0;
            r_xcnt    <= '0;
            r_row     <= '0;
            r_fcnt    <= '0;
            r_win     <= '0;
            r_max_run <= '0;
            for (int k = 0; k < N; k++) begin
                r_b_buf[k] <= '0;
            end
            r_valid   <= 1'b0;
            r_idx     <= '0;
            r_out     <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            max_abs   <= '0;
            proto_err <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            done    <= 1'b0;

            if (w_shift) begin
                r_win <= w_win_next[7*XW-1:XW];
            end

            if (w_emit) begin
                r_valid   <= 1'b1;
                r_idx     <= 6'(r_row);
                r_out     <= w_r;
                r_max_run <= w_max_next;
                if (r_row != LAST) begin
                    r_row <= r_row + 1'b1;
                end
            end

            if ((b_valid && (r_state != LOAD_B)) || (x_valid && (r_state != RUN))) begin
                proto_err <= 1'b1;
            end

            case (r_state)
                LOAD_B: begin
                    if (b_valid) begin
                        r_b_buf[r_bcnt] <= b_in;
                        if (r_bcnt == LAST) begin
                            r_bcnt    <= '0;
                            r_xcnt    <= '0;
                            r_row     <= '0;
                            r_win     <= '0;
                            r_max_run <= '0;
                            r_state   <= RUN;
                        end else begin
                            r_bcnt <= r_bcnt + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (x_valid) begin
                        if (r_xcnt == LAST) begin
                            r_fcnt  <= '0;
                            r_state <= FLUSH;
                        end else begin
                            r_xcnt <= r_xcnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (r_fcnt == 2'd2) begin
                        r_state <= DONE;
                    end else begin
                        r_fcnt <= r_fcnt + 1'b1;
                    end
                end
                DONE: begin
                    done    <= 1'b1;
                    pass    <= (r_max_run <= TOL);
                    max_abs <= r_max_run;
                    r_state <= LOAD_B;
                end
                default: r_state <= LOAD_B;
            endcase
        end
    end

endmodule

// File: tb/tb_gsim_residual_chk.sv
// Bench for gsim_residual_chk: a reference model fills a scoreboard queue as x is
// driven; a negedge monitor pops and compares residuals, timing and end-of-run results.
module tb_gsim_residual_chk;
    import gsim_pkg::*;

    localparam int N  = 16;
    localparam int BW = 16;
    localparam int XW = 32;
    localparam int RW = 40;

    logic          clk = 1'b0;
    logic          reset;
    logic          b_valid;
    logic [BW-1:0] b_in;
    logic          x_valid;
    logic [XW-1:0] x_in;
    logic          r_valid;
    logic [5:0]    r_idx;
    logic [RW-1:0] r_out;
    logic          done;
    logic          pass;
    logic [RW-1:0] max_abs;
    logic          proto_err;
    state_t        dbg_state;

    logic          t_r_valid;
    logic [5:0]    t_r_idx;
    logic [RW-1:0] t_r_out;
    logic          t_done;
    logic          t_pass;
    logic [RW-1:0] t_max_abs;
    logic          t_proto_err;
    state_t        t_dbg_state;

    gsim_residual_chk u_dut (
        .clk(clk), .reset(reset), .b_valid(b_valid), .b_in(b_in),
        .x_valid(x_valid), .x_in(x_in), .r_valid(r_valid), .r_idx(r_idx),
        .r_out(r_out), .done(done), .pass(pass), .max_abs(max_abs),
        .proto_err(proto_err), .dbg_state(dbg_state)
    );

    gsim_residual_chk #(.TOL(40'h00_0001_0000)) u_dut_tol (
        .clk(clk), .reset(reset), .b_valid(b_valid), .b_in(b_in),
        .x_valid(x_valid), .x_in(x_in), .r_valid(t_r_valid), .r_idx(t_r_idx),
        .r_out(t_r_out), .done(t_done), .pass(t_pass), .max_abs(t_max_abs),
        .proto_err(t_proto_err), .dbg_state(t_dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int            b_v [N];
    int            x_v [N];
    logic [RW-1:0] exp_r [N];
    logic [RW-1:0] exp_max;
    logic          exp_pass;
    logic          exp_pass_tol;

    function automatic longint coef(input int off);
        case (off)
            0:       return 20;
            1, -1:   return -13;
            2, -2:   return 6;
            3, -3:   return -1;
            default: return 0;
        endcase
    endfunction

    function automatic void model();
        longint mx;
        mx = 0;
        for (int i = 0; i < N; i++) begin
            longint acc;
            longint a;
            acc = 0;
            for (int d = -3; d <= 3; d++) begin
                if (i + d >= 0 && i + d < N) acc += coef(d) * longint'(x_v[i+d]);
            end
            acc -= longint'(b_v[i]) * 65536;
            exp_r[i] = acc[RW-1:0];
            a = (acc < 0) ? -acc : acc;
            if (a > mx) mx = a;
        end
        exp_max      = mx[RW-1:0];
        exp_pass     = (mx <= 64'h100);
        exp_pass_tol = (mx <= 64'h10000);
    endfunction

    // ---------------- scoreboard ----------------
    logic [77:0] exp_q [$];   // {row, residual, expected cycle}
    logic [73:0] done_q [$];  // {cycle, max_abs, pass, pass with TOL=1.0}
    logic [77:0] e_r;
    logic [73:0] e_d;

    always @(negedge clk) begin
        if (r_valid) begin
            if (exp_q.size() == 0) begin
                check_val("r_unexpected", 64'(r_idx), 64'hFFFF);
            end else begin
                e_r = exp_q.pop_front();
                check_val("r_idx", 64'(r_idx), 64'(e_r[77:72]));
                check_val("r_out", 64'(r_out), 64'(e_r[71:32]));
                check_val("r_cycle", 64'(cyc), 64'(e_r[31:0]));
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                check_val("done_unexpected", 64'(done), 64'h0);
            end else begin
                e_d = done_q.pop_front();
                check_val("done_cycle", 64'(cyc), 64'(e_d[73:42]));
                check_val("max_abs", 64'(max_abs), 64'(e_d[41:2]));
                check_val("pass", 64'(pass), 64'(e_d[1]));
                check_val("pass_tol", 64'(t_pass), 64'(e_d[0]));
                check_val("done_tol", 64'(t_done), 64'h1);
                check_val("max_abs_tol", 64'(t_max_abs), 64'(e_d[41:2]));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic do_reset();
        reset   = 1'b1;
        b_valid = 1'b0;
        x_valid = 1'b0;
        b_in    = '0;
        x_in    = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic load_b(input bit with_x);
        for (int i = 0; i < N; i++) begin
            b_valid = 1'b1;
            b_in    = b_v[i][BW-1:0];
            if (i == 0 && with_x) begin
                x_valid = 1'b1;
                x_in    = 32'h0000_1234;
            end
            @(posedge clk);
            #1;
            x_valid = 1'b0;
        end
        b_valid = 1'b0;
    endtask

    task automatic run_x(input int beats, input int gmin, input int gmax);
        for (int j = 0; j < beats; j++) begin
            x_valid = 1'b1;
            x_in    = x_v[j];
            if (j >= 3) exp_q.push_back({6'(j-3), exp_r[j-3], 32'(cyc + 1)});
            if (j == N - 1) begin
                for (int k = 0; k < 3; k++) begin
                    exp_q.push_back({6'(N-3+k), exp_r[N-3+k], 32'(cyc + 2 + k)});
                end
                done_q.push_back({32'(cyc + 5), exp_max, exp_pass, exp_pass_tol});
            end
            @(posedge clk);
            #1;
            x_valid = 1'b0;
            if (j < beats - 1) begin
                repeat ($urandom_range(gmin, gmax)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && (exp_q.size() != 0 || done_q.size() != 0); k++) begin
            @(posedge clk);
            #1;
        end
        check_val("drain_r", 64'(exp_q.size()), 64'h0);
        check_val("drain_done", 64'(done_q.size()), 64'h0);
    endtask

    task automatic set_vec(input int bval, input int xval);
        for (int i = 0; i < N; i++) begin
            b_v[i] = bval;
            x_v[i] = xval;
        end
    endtask

    task automatic full_run(input int gmin, input int gmax);
        model();
        load_b(1'b0);
        run_x(N, gmin, gmax);
        drain();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        do_reset();
        check_val("rst_r_valid", 64'(r_valid), 64'h0);
        check_val("rst_done", 64'(done), 64'h0);
        check_val("rst_pass", 64'(pass), 64'h0);
        check_val("rst_max_abs", 64'(max_abs), 64'h0);
        check_val("rst_proto_err", 64'(proto_err), 64'h0);
        check_val("rst_state", 64'(dbg_state), 64'(LOAD_B));

        // Test 1: all zero
        set_vec(0, 0);
        full_run(0, 0);
        check_val("t1_pass", 64'(pass), 64'h1);
        check_val("t1_max_abs", 64'(max_abs), 64'h0);

        // Test 2: x = 1.0
        set_vec(0, 32'h0001_0000);
        full_run(0, 0);
        check_val("t2_max_abs", 64'(max_abs), 64'h0C_0000);
        check_val("t2_pass", 64'(pass), 64'h0);

        // Test 3: impulse at x[7]
        set_vec(0, 0);
        x_v[7] = 32'h0001_0000;
        full_run(0, 0);
        check_val("t3_max_abs", 64'(max_abs), 64'h14_0000);

        // Test 4: Test 2 with two idle cycles between beats
        set_vec(0, 32'h0001_0000);
        full_run(2, 2);
        check_val("t4_max_abs", 64'(max_abs), 64'h0C_0000);

        // Test 5: b[0] = -1
        set_vec(0, 0);
        b_v[0] = -1;
        full_run(0, 0);
        check_val("t5_max_abs", 64'(max_abs), 64'h1_0000);
        check_val("t5_pass", 64'(pass), 64'h0);
        check_val("t5_pass_tol", 64'(t_pass), 64'h1);

        // Random data with random gaps
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) begin
                b_v[i] = int'($urandom_range(0, 65535)) - 32768;
                x_v[i] = int'($urandom());
            end
            full_run(0, 3);
        end
        check_val("proto_clean", 64'(proto_err), 64'h0);

        // Test 6: abort after x[8], then a full Test 2 run
        set_vec(0, 32'h0001_0000);
        model();
        load_b(1'b0);
        run_x(9, 0, 0);
        do_reset();
        check_val("abort_q", 64'(exp_q.size()), 64'h0);
        check_val("abort_state", 64'(dbg_state), 64'(LOAD_B));
        check_val("abort_max_abs", 64'(max_abs), 64'h0);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        full_run(0, 0);
        check_val("t6_max_abs", 64'(max_abs), 64'h0C_0000);
        check_val("t6_proto_err", 64'(proto_err), 64'h0);

        // x_valid during LOAD_B together with b_valid: b kept, x dropped
        b_v[0] = 5;
        model();
        load_b(1'b1);
        check_val("lb_proto_err", 64'(proto_err), 64'h1);
        check_val("lb_max_abs_held", 64'(max_abs), 64'h0C_0000);
        check_val("lb_pass_held", 64'(pass), 64'h0);
        run_x(N, 0, 1);
        drain();
        check_val("lb_proto_sticky", 64'(proto_err), 64'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
